fighter_pose_ctrl: RTL and testbench

FIGHTER_POSE_CTRL -- requirements
Module: fighter_pose_ctrl

---
 rtl/fighter_pkg.sv | 35 +++
 rtl/fighter_pose_chan.sv | 141 ++++++++++++++
 rtl/fighter_pose_ctrl.sv | 50 +++++
 tb/tb_fighter_pose_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared types for the fighter pose controller: channel state encoding,
// pose codes and the action request priority.
package fighter_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK_L  = 3'd1,
    ST_WALK_R  = 3'd2,
    ST_ACTION  = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam logic [2:0] POSE_STAND   = 3'd0;
  localparam logic [2:0] POSE_WALK    = 3'd1;
  localparam logic [2:0] POSE_PUNCH   = 3'd2;
  localparam logic [2:0] POSE_KICK    = 3'd3;
  localparam logic [2:0] POSE_JUMP    = 3'd4;
  localparam logic [2:0] POSE_DODGE   = 3'd5;
  localparam logic [2:0] POSE_RECOVER = 3'd6;

  // Simultaneous requests resolve dodge > jump > kick > fight.
  function automatic logic [2:0] action_pose(input logic kick, input logic fight,
                                             input logic jump, input logic dodge);
    logic [2:0] p;
    p = POSE_STAND;
    if (dodge)      p = POSE_DODGE;
    else if (jump)  p = POSE_JUMP;
    else if (kick)  p = POSE_KICK;
    else if (fight) p = POSE_PUNCH;
    return p;
  endfunction

endpackage

// File: rtl/fighter_pose_chan.sv
// One fighter channel: movement/action FSM with tick-driven action and
// recovery timers; every output is registered from the next-state decode.
module fighter_pose_chan
  import fighter_pkg::*;
#(
  parameter int ACT_CYCLES      = 8,
  parameter int RECOVER_CYCLES  = 4,
  parameter bit RESET_FACE_LEFT = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       left,
  input  logic       right,
  input  logic       kick,
  input  logic       fight,
  input  logic       jump,
  input  logic       dodge,
  output logic       face_left,
  output logic [2:0] pose,
  output logic       busy,
  output logic       action_done
);

  localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD =
    (RECOVER_CYCLES == 0) ? '0 : CNT_W'(RECOVER_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       act_pose_reg, act_pose_next;
  logic             face_reg, face_next;
  logic [2:0]       pose_reg, pose_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             any_action;

  assign any_action = kick | fight | jump | dodge;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    act_pose_next = act_pose_reg;
    face_next     = face_reg;
    done_next     = 1'b0;

    case (state_reg)
      ST_IDLE, ST_WALK_L, ST_WALK_R: begin
        if (any_action) begin
          state_next    = ST_ACTION;
          cnt_next      = ACT_LOAD;
          act_pose_next = action_pose(kick, fight, jump, dodge);
        end else if (left && !right) begin
          state_next = ST_WALK_L;
          face_next  = 1'b1;
        end else if (right && !left) begin
          state_next = ST_WALK_R;
          face_next  = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_ACTION: begin
        if (tick) begin
          if (cnt_reg == '0) begin
            done_next = 1'b1;
            if (RECOVER_CYCLES == 0) begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end else begin
              state_next = ST_RECOVER;
              cnt_next   = REC_LOAD;
            end
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end

      ST_RECOVER: begin
        if (tick) begin
          if (cnt_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear one edge after the inputs.
  always_comb begin
    pose_next = POSE_STAND;
    busy_next = 1'b0;
    case (state_next)
      ST_WALK_L, ST_WALK_R: pose_next = POSE_WALK;
      ST_ACTION: begin
        pose_next = act_pose_next;
        busy_next = 1'b1;
      end
      ST_RECOVER: begin
        pose_next = POSE_RECOVER;
        busy_next = 1'b1;
      end
      default: pose_next = POSE_STAND;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      act_pose_reg <= POSE_STAND;
      face_reg     <= RESET_FACE_LEFT;
      pose_reg     <= POSE_STAND;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      act_pose_reg <= act_pose_next;
      face_reg     <= face_next;
      pose_reg     <= pose_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign face_left   = face_reg;
  assign pose        = pose_reg;
  assign busy        = busy_reg;
  assign action_done = done_reg;

endmodule

// File: rtl/fighter_pose_ctrl.sv
// Multi-player pose controller: one independent channel per player,
// the top level only slices and packs the per-player vectors.
module fighter_pose_ctrl
  import fighter_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int ACT_CYCLES     = 8,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     tick,
  input  logic [NUM_PLAYERS-1:0]   left,
  input  logic [NUM_PLAYERS-1:0]   right,
  input  logic [NUM_PLAYERS-1:0]   kick,
  input  logic [NUM_PLAYERS-1:0]   fight,
  input  logic [NUM_PLAYERS-1:0]   jump,
  input  logic [NUM_PLAYERS-1:0]   dodge,
  output logic [NUM_PLAYERS-1:0]   face_left,
  output logic [3*NUM_PLAYERS-1:0] pose,
  output logic [NUM_PLAYERS-1:0]   busy,
  output logic [NUM_PLAYERS-1:0]   action_done
);

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_chan
      // Player 0 starts facing right, everyone else faces left toward it.
      fighter_pose_chan #(
        .ACT_CYCLES     (ACT_CYCLES),
        .RECOVER_CYCLES (RECOVER_CYCLES),
        .RESET_FACE_LEFT(gi != 0)
      ) u_chan (
        .Clk        (Clk),
        .Reset      (Reset),
        .tick       (tick),
        .left       (left[gi]),
        .right      (right[gi]),
        .kick       (kick[gi]),
        .fight      (fight[gi]),
        .jump       (jump[gi]),
        .dodge      (dodge[gi]),
        .face_left  (face_left[gi]),
        .pose       (pose[3*gi +: 3]),
        .busy       (busy[gi]),
        .action_done(action_done[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fighter_pose_ctrl.sv
// Bench for fighter_pose_ctrl: directed table, corner sequences and random
// traffic against a remaining-ticks reference model (REC=4 and REC=0 builds).
module tb_fighter_pose_ctrl;

  localparam int NP  = 2;
  localparam int ACT = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          tick;
  logic [NP-1:0] left, right, kick, fight, jump, dodge;

  logic [NP-1:0]   face_a, busy_a, done_a;
  logic [3*NP-1:0] pose_a;
  logic [NP-1:0]   face_b, busy_b, done_b;
  logic [3*NP-1:0] pose_b;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  fighter_pose_ctrl #(.NUM_PLAYERS(NP), .ACT_CYCLES(ACT), .RECOVER_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .tick(tick), .left(left), .right(right),
    .kick(kick), .fight(fight), .jump(jump), .dodge(dodge),
    .face_left(face_a), .pose(pose_a), .busy(busy_a), .action_done(done_a));

  fighter_pose_ctrl #(.NUM_PLAYERS(NP), .ACT_CYCLES(ACT), .RECOVER_CYCLES(0)) dut_r0 (
    .Clk(Clk), .Reset(Reset), .tick(tick), .left(left), .right(right),
    .kick(kick), .fight(fight), .jump(jump), .dodge(dodge),
    .face_left(face_b), .pose(pose_b), .busy(busy_b), .action_done(done_b));

  // Reference model: mode 0 idle, 1 walk left, 2 walk right, 3 action, 4 recover.
  // rem counts ticks still needed before the phase ends.
  int         rec_cfg[2] = '{4, 0};
  int         m_mode[2][NP];
  int         m_rem[2][NP];
  logic       m_face[2][NP];
  logic [2:0] m_act[2][NP];
  logic       m_done[2][NP];

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < NP; p++) begin
        m_done[c][p] = 1'b0;
        if (Reset) begin
          m_mode[c][p] = 0;
          m_rem[c][p]  = 0;
          m_face[c][p] = (p != 0);
          m_act[c][p]  = 3'd0;
        end else if (m_mode[c][p] <= 2) begin
          if (kick[p] || fight[p] || jump[p] || dodge[p]) begin
            m_mode[c][p] = 3;
            m_rem[c][p]  = ACT;
            if (dodge[p])     m_act[c][p] = 3'd5;
            else if (jump[p]) m_act[c][p] = 3'd4;
            else if (kick[p]) m_act[c][p] = 3'd3;
            else              m_act[c][p] = 3'd2;
          end else if (left[p] && !right[p]) begin
            m_mode[c][p] = 1;
            m_face[c][p] = 1'b1;
          end else if (right[p] && !left[p]) begin
            m_mode[c][p] = 2;
            m_face[c][p] = 1'b0;
          end else begin
            m_mode[c][p] = 0;
          end
        end else if (tick) begin
          m_rem[c][p] = m_rem[c][p] - 1;
          if (m_rem[c][p] == 0) begin
            if (m_mode[c][p] == 3) begin
              m_done[c][p] = 1'b1;
              if (rec_cfg[c] == 0) m_mode[c][p] = 0;
              else begin
                m_mode[c][p] = 4;
                m_rem[c][p]  = rec_cfg[c];
              end
            end else begin
              m_mode[c][p] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [NP-1:0]   ef, eb, ed, af, ab, ad;
    logic [3*NP-1:0] ep, ap;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < NP; p++) begin
        ef[p] = m_face[c][p];
        ed[p] = m_done[c][p];
        eb[p] = (m_mode[c][p] >= 3);
        case (m_mode[c][p])
          1, 2:    ep[3*p +: 3] = 3'd1;
          3:       ep[3*p +: 3] = m_act[c][p];
          4:       ep[3*p +: 3] = 3'd6;
          default: ep[3*p +: 3] = 3'd0;
        endcase
      end
      af = (c == 0) ? face_a : face_b;
      ap = (c == 0) ? pose_a : pose_b;
      ab = (c == 0) ? busy_a : busy_b;
      ad = (c == 0) ? done_a : done_b;
      checks++;
      if (af !== ef || ap !== ep || ab !== eb || ad !== ed) begin
        failures++;
        $display("FAIL model_cfg%0d t=%0t: got face=%b pose=%o busy=%b done=%b, want face=%b pose=%o busy=%b done=%b",
                 c, $time, af, ap, ab, ad, ef, ep, eb, ed);
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge Clk);
    #1;
    compare_model();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  task automatic clear_inputs();
    Reset = 1'b0; tick = 1'b0;
    left = '0; right = '0; kick = '0; fight = '0; jump = '0; dodge = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic          tk;
    logic [NP-1:0] l, r, k, f, j, d;
    logic [NP-1:0] e_face;
    logic [5:0]    e_pose;
    logic [NP-1:0] e_busy;
    logic [NP-1:0] e_done;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [1:0] rnd_bits(input int one_in);
    logic [1:0] b;
    for (int i = 0; i < 2; i++) b[i] = ($urandom_range(0, one_in - 1) == 0);
    return b;
  endfunction

  initial begin
    int ticks_seen;
    bit was_action;
    bit exited;

    clear_inputs();

    //            rst tk  l      r      k      f      j      d      face   pose   busy   done
    tbl[0] = '{1'b1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 6'o00, 2'b00, 2'b00};
    tbl[1] = '{1'b0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 6'o00, 2'b00, 2'b00};
    tbl[2] = '{1'b0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 6'o01, 2'b00, 2'b00};
    tbl[3] = '{1'b0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 6'o01, 2'b00, 2'b00};
    tbl[4] = '{1'b0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 6'o00, 2'b00, 2'b00};
    tbl[5] = '{1'b0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 6'o10, 2'b00, 2'b00};
    tbl[6] = '{1'b0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 6'o30, 2'b10, 2'b00};
    tbl[7] = '{1'b0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 6'o30, 2'b10, 2'b00};
    tbl[8] = '{1'b0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 6'o31, 2'b10, 2'b00};
    tbl[9] = '{1'b1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 6'o00, 2'b00, 2'b00};

    for (int i = 0; i < 10; i++) begin
      Reset = tbl[i].rst; tick = tbl[i].tk;
      left = tbl[i].l; right = tbl[i].r; kick = tbl[i].k;
      fight = tbl[i].f; jump = tbl[i].j; dodge = tbl[i].d;
      cycle();
      chk($sformatf("tbl%0d_face", i), 32'(face_a), 32'(tbl[i].e_face));
      chk($sformatf("tbl%0d_pose", i), 32'(pose_a), 32'(tbl[i].e_pose));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), 32'(done_a), 32'(tbl[i].e_done));
      $display("vec %0d: face=%b pose=%o busy=%b done=%b", i, face_a, pose_a, busy_a, done_a);
    end

    // P1 kick+dodge with a tick every cycle: dodge wins, 8 action + 4 recover cycles.
    do_reset();
    tick = 1'b1; kick = 2'b10; dodge = 2'b10;
    cycle();
    kick = '0; dodge = '0;
    for (int c = 0; c < 13; c++) begin
      chk($sformatf("kd_pose1_c%0d", c), 32'(pose_a[5:3]),
          (c < 8) ? 32'd5 : (c < 12) ? 32'd6 : 32'd0);
      chk($sformatf("kd_busy1_c%0d", c), 32'(busy_a[1]), 32'(c < 12));
      chk($sformatf("kd_done1_c%0d", c), 32'(done_a[1]), 32'(c == 8));
      chk($sformatf("r0_pose1_c%0d", c), 32'(pose_b[5:3]), (c < 8) ? 32'd5 : 32'd0);
      chk($sformatf("r0_done1_c%0d", c), 32'(done_b[1]), 32'(c == 8));
      $display("kd c=%0d pose1=%0d busy1=%b done1=%b r0_pose1=%0d", c, pose_a[5:3], busy_a[1], done_a[1], pose_b[5:3]);
      cycle();
    end

    // P0 fight with sparse ticks and left pulses that must be ignored.
    do_reset();
    fight = 2'b01;
    cycle();
    fight = '0;
    ticks_seen = 0;
    exited = 0;
    for (int cyc = 0; cyc < 100 && !exited; cyc++) begin
      tick = (cyc % 3 == 2);
      left = (cyc % 5 == 0) ? 2'b01 : 2'b00;
      was_action = (pose_a[2:0] == 3'd2);
      cycle();
      if (was_action && tick) ticks_seen++;
      if (pose_a[2:0] != 3'd2) exited = 1;
    end
    chk("slow_exit_seen", 32'(exited), 32'd1);
    chk("slow_ticks", ticks_seen, ACT);
    chk("slow_face0", 32'(face_a[0]), 32'd0);
    $display("slow fight: ticks=%0d face0=%b", ticks_seen, face_a[0]);
    clear_inputs();

    // Reset in the third cycle of a P0 action after it turned left.
    do_reset();
    left = 2'b01;
    cycle();
    chk("mid_face_before", 32'(face_a[0]), 32'd1);
    left = '0; fight = 2'b01; tick = 1'b1;
    cycle();
    fight = '0;
    cycle();
    cycle();
    chk("mid_busy_before", 32'(busy_a[0]), 32'd1);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    chk("mid_pose0", 32'(pose_a[2:0]), 32'd0);
    chk("mid_busy0", 32'(busy_a[0]), 32'd0);
    chk("mid_face0", 32'(face_a[0]), 32'd0);
    chk("mid_done0", 32'(done_a[0]), 32'd0);
    $display("mid reset: pose0=%0d busy0=%b face0=%b done0=%b", pose_a[2:0], busy_a[0], face_a[0], done_a[0]);

    // Random traffic, both builds checked against the model every cycle.
    clear_inputs();
    for (int n = 0; n < 3000; n++) begin
      Reset = ($urandom_range(0, 99) == 0);
      tick  = $urandom_range(0, 1);
      left  = rnd_bits(2);
      right = rnd_bits(2);
      kick  = rnd_bits(10);
      fight = rnd_bits(10);
      jump  = rnd_bits(10);
      dodge = rnd_bits(10);
      cycle();
    end
    $display("random: 3000 cycles applied");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
